// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with start/busy/done handshake and iterative shift-add multiply
module seq_alu #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    state_t state, state_next;

    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [CW-1:0]      cnt;
    logic               is_mul;

    logic               sub_op;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic               add_ovf;
    logic [WIDTH:0]     partial;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry, alu_ovf;

    assign is_mul = MUL_EN && (op == OP_MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = is_mul ? S_MUL : S_EXEC;
            S_EXEC: state_next = S_DONE;
            S_MUL:  if (cnt == CW'(1)) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_EXEC) || (state == S_MUL);
        done = (state == S_DONE);
    end

    // SLT reuses the subtractor: sign of a-b corrected by signed overflow
    assign sub_op  = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign b_eff   = sub_op ? ~b_q : b_q;
    assign sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    assign add_ovf = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op_q)
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_NOR: alu_res = ~(a_q | b_q);
            OP_ADD, OP_SUB: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = add_ovf;
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            default: alu_res = '0;
        endcase
    end

    // Accumulator holds {partial product, remaining multiplier bits}; shift right each step
    assign partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign acc_step = {partial, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                        acc  <= {{WIDTH{1'b0}}, b};
                        cnt  <= CW'(WIDTH);
                    end
                end
                S_EXEC: begin
                    result    <= alu_res;
                    carry_out <= alu_carry;
                    overflow  <= alu_ovf;
                    zero      <= (alu_res == '0);
                end
                S_MUL: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result    <= acc_step[WIDTH-1:0];
                        carry_out <= 1'b0;
                        overflow  <= |acc_step[2*WIDTH-1:WIDTH];
                        zero      <= (acc_step[WIDTH-1:0] == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized model-checked bench for seq_alu with pinned directed cases
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] result;
    logic        carry_out, overflow, zero, busy, done;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    seq_alu dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .result(result), .carry_out(carry_out), .overflow(overflow),
        .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic c, output logic v,
                                  output int lat);
        longint            s;
        longint unsigned   u;
        logic [63:0]       p;
        r = 32'd0; c = 1'b0; v = 1'b0; lat = 2;
        case (o)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b1100: r = ~(x | y);
            4'b0010: begin
                u = {32'd0, x} + {32'd0, y};
                r = x + y;
                c = (u > 64'hffff_ffff);
                s = longint'($signed(x)) + longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                r = x - y;
                c = (x >= y);
                s = longint'($signed(x)) - longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1000: begin
                p = {32'd0, x} * {32'd0, y};
                r = p[31:0];
                v = (p[63:32] != 32'd0);
                lat = 33;
            end
            default: r = 32'd0;
        endcase
    endfunction

    // Reference model: one operation in flight, outputs change only at completion or reset
    bit          chk_en = 0;
    bit          pend = 0;
    bit          was_pend;
    int          done_at = 0;
    logic [31:0] exp_res = '0, p_res;
    logic        exp_c = 0, exp_v = 0, exp_z = 0, p_c, p_v;
    int          p_lat;

    always @(negedge clk) begin
        if (pend && cyc == done_at) begin
            exp_res = p_res; exp_c = p_c; exp_v = p_v; exp_z = (p_res == 32'd0);
        end
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, pend && cyc < done_at});
            chk("done", {31'd0, done}, {31'd0, pend && cyc == done_at});
            chk("result", result, exp_res);
            chk("carry_out", {31'd0, carry_out}, {31'd0, exp_c});
            chk("overflow", {31'd0, overflow}, {31'd0, exp_v});
            chk("zero", {31'd0, zero}, {31'd0, exp_z});
        end
        if (rst) begin
            pend = 0; exp_res = '0; exp_c = 0; exp_v = 0; exp_z = 0; chk_en = 1;
        end else begin
            was_pend = pend;
            if (pend && cyc == done_at) pend = 0;
            if (!was_pend && start) begin
                model(op, a, b, p_res, p_c, p_v, p_lat);
                pend = 1;
                done_at = cyc + p_lat;
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int t0);
        @(posedge clk); #1;
        start = 1; op = o; a = x; b = y; t0 = cyc;
        @(posedge clk); #1;
        start = 0; op = 4'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic ec, input logic ev, input logic ez, input int el);
        int t0, lat;
        issue(o, x, y, t0);
        wait_done(t0, lat);
        chk({name, "_latency"}, 32'(lat), 32'(el));
        chk({name, "_result"}, result, er);
        chk({name, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
        chk({name, "_overflow"}, {31'd0, overflow}, {31'd0, ev});
        chk({name, "_zero"}, {31'd0, zero}, {31'd0, ez});
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hffff_ffff;
            2: return 32'h8000_0000;
            3: return 32'h7fff_ffff;
            4: return 32'($urandom_range(0, 65535));
            default: return $urandom;
        endcase
    endfunction

    logic [3:0] op_tbl [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                                4'b1100, 4'b1000, 4'b0101, 4'b1111, 4'b0011};

    initial begin
        int t0, lat, ndone, dcyc;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {28'd0, carry_out, overflow, zero, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 0;

        run_op("and", 4'b0000, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h00000000, 0, 0, 1, 2);
        run_op("or",  4'b0001, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'hffffffff, 0, 0, 0, 2);
        run_op("add", 4'b0010, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'hffffffff, 0, 0, 0, 2);
        run_op("sub", 4'b0110, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h4b4b4b4b, 1, 1, 0, 2);
        run_op("slt1", 4'b0111, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h00000001, 0, 0, 0, 2);
        run_op("slt0", 4'b0111, 32'h5a5a5a5a, 32'ha5a5a5a5, 32'h00000000, 0, 0, 1, 2);
        run_op("nor", 4'b1100, 32'h0f0f0000, 32'h00f0f000, 32'hf0000fff, 0, 0, 0, 2);
        run_op("undef", 4'b0101, 32'h12345678, 32'h9abcdef0, 32'h00000000, 0, 0, 1, 2);
        run_op("mul", 4'b1000, 32'h00001234, 32'h00000010, 32'h00012340, 0, 0, 0, 33);
        run_op("mul_ovf", 4'b1000, 32'h00010000, 32'h00010000, 32'h00000000, 0, 1, 1, 33);

        // start with another op during a multiply must be ignored
        issue(4'b1000, 32'h00001234, 32'h00000010, t0);
        repeat (4) @(posedge clk); #1;
        start = 1; op = 4'b0010; a = 32'd1; b = 32'd1;
        @(posedge clk); #1;
        start = 0;
        ndone = 0; dcyc = -1;
        while (cyc < t0 + 40) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                dcyc = cyc - t0;
                chk("mul_ign_result", result, 32'h00012340);
            end
        end
        chk("mul_ign_done_count", 32'(ndone), 32'd1);
        chk("mul_ign_done_cycle", 32'(dcyc), 32'd33);

        // reset in the middle of a multiply aborts it silently
        issue(4'b1000, 32'h00001234, 32'h00000010, t0);
        repeat (9) @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_mul_result", result, 32'd0);
        chk("rst_mul_flags", {27'd0, carry_out, overflow, zero, busy, done}, 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("rst_mul_no_done", 32'(ndone), 32'd0);
        run_op("add_after_rst", 4'b0010, 32'd3, 32'd4, 32'h00000007, 0, 0, 0, 2);

        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            op    = op_tbl[$urandom_range(0, 9)];
            a     = pick_val();
            b     = pick_val();
        end
        @(posedge clk); #1;
        rst = 0; start = 0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the combinational 32-bit ALU (AND/OR/ADD/SUB). Adds SLT, NOR and an iterative shift-add multiply, plus Zero and Overflow flags. Uses a start/busy/done handshake so the datapath control can issue operations and wait for variable latency. It sits between the register-file read ports and the writeback mux in the multi-cycle datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
MUL_EN, 1, 1 enables the multiply op; 0 makes op 1000 behave as an undefined op

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL
a  input  WIDTH  operand A, captured with start
b  input  WIDTH  operand B, captured with start
result  output  WIDTH  registered result
carry_out  output  1  carry out of MSB (ADD/SUB), else 0
overflow  output  1  signed overflow (ADD/SUB), unsigned high-half-nonzero (MUL), else 0
zero  output  1  result == 0
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse, outputs valid

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, result=0, carry_out=0, overflow=0, zero=0, busy=0, done=0, multiply counter/accumulator cleared. Reset wins over start. Reset mid-MUL aborts with no done pulse.
- States: IDLE, EXEC, MUL, DONE.
- IDLE: start=1 in cycle T captures a, b and op. MUL (MUL_EN=1) goes to MUL and loads counter=WIDTH. All other ops go to EXEC. busy=1 from cycle T+1.
- EXEC: computes for one cycle and goes to DONE. Outputs are registered into result/flags and are visible in cycle T+2, with done=1 and busy=0 in T+2.
- ADD: a+b. SUB: a+~b+1. carry_out is the MSB carry, so SUB carry_out=1 iff a>=b unsigned. overflow = operands (b inverted for SUB) have the same sign and the result sign differs.
- SLT: result = {0..., (a<b signed)}, computed from the SUB sign xor overflow. carry_out=0, overflow=0.
- AND/OR/NOR: bitwise, carry_out=0, overflow=0.
- Undefined op: result=0, zero=1, carry_out=0, overflow=0. Handshake and latency are the same as for single-cycle ops.
- MUL: unsigned shift-add, one multiplier bit per cycle, LSB first, with a 2*WIDTH accumulator.
  - Counter decrements each cycle; WIDTH iterations occupy cycles T+1..T+WIDTH.
  - Then DONE: result = low WIDTH bits, overflow = |high WIDTH bits, carry_out=0.
  - done=1 in cycle T+WIDTH+1.
- DONE: lasts one cycle, done=1, busy=0, then returns to IDLE.
  - start in the DONE cycle is ignored; the earliest accepted start is the next cycle.
  - Back-to-back single-cycle op issue rate is one per 3 cycles.
- start while busy=1 is ignored; captured operands are unaffected by changes on a, b or op.
- result/flags hold their last values until the next completion. zero always reflects the registered result.
- Widths: all internal arithmetic is WIDTH+1 bits for carry and 2*WIDTH bits for MUL. There are no truncation warnings for WIDTH=4..64.

Test Plan:
- WIDTH=32, a=a5a5a5a5, b=5a5a5a5a, op AND -> result 00000000, zero=1, done at T+2. OR -> ffffffff, zero=0.
- Same operands, ADD -> ffffffff, carry_out=0, overflow=0. SUB -> 4b4b4b4b, carry_out=1, overflow=1.
- SLT a=a5a5a5a5, b=5a5a5a5a -> 00000001. SLT a=5a5a5a5a, b=a5a5a5a5 -> 00000000, zero=1. Undefined op 0101 -> result 0, done at T+2.
- MUL a=00001234, b=00000010 -> result 00012340, overflow=0, done only at T+33, busy high T+1..T+32. MUL a=b=00010000 -> result 0, zero=1, overflow=1.
- start pulsed with a different op at T+5 during a MUL -> ignored, original product delivered at T+33, exactly one done pulse.
- rst asserted at T+10 during a MUL -> all outputs 0 next cycle, no done. A new ADD 3+4 then returns 00000007 at its T'+2.
